delta_sigma_dac: RTL and testbench

- First-order 1-bit delta-sigma modulator. Converts C_DAT_W-bit unsigned samples into a pulse-density bitstream.
- The bitstream feeds a pad-driven RC filter, or the in-fabric first-order IIR low-pass filter, which recovers DAT/2^C_DAT_W.
- Samples arrive over a valid/ready handshake into a one-entry pending buffer. Each active sample is held for C_OSR modulator ticks, then the next one is taken.
- Modulator ticks are qualified by EN_CK_i.

---
 rtl/delta_sigma_dac.sv | 148 ++++++++++++++
 tb/tb_delta_sigma_dac.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/delta_sigma_dac.sv
// First-order 1-bit delta-sigma modulator. Samples enter through a valid/ready
// handshake into a one-entry pending buffer. Each active sample is held for C_OSR ticks.
module delta_sigma_dac #(
  parameter int C_DAT_W = 8,
  parameter int C_OSR   = 256,
  parameter int C_OSR_W = 8
) (
  input  logic               CK_i,
  input  logic               XARST_i,
  input  logic               EN_CK_i,
  input  logic               RUN_i,
  input  logic [C_DAT_W-1:0] DAT_i,
  input  logic               DAT_VLD_i,
  output logic               DAT_RDY_o,
  output logic               BIT_o,
  output logic               UNDERRUN_o,
  input  logic               UNDERRUN_CLR_i,
  output logic [C_DAT_W-1:0] ACC_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [C_OSR_W-1:0] CNT_LAST = C_OSR_W'(C_OSR - 1);
  localparam logic [C_OSR_W-1:0] CNT_ONE  = C_OSR_W'(1);
  localparam logic [C_OSR_W-1:0] CNT_ZERO = C_OSR_W'(0);
  localparam logic [C_DAT_W-1:0] DAT_ZERO = C_DAT_W'(0);

  state_t             state_q, state_d;
  logic [C_DAT_W-1:0] pend_q, pend_d;
  logic               pend_full_q, pend_full_d;
  logic [C_DAT_W-1:0] active_q, active_d;
  logic [C_DAT_W-1:0] acc_q, acc_d;
  logic [C_OSR_W-1:0] cnt_q, cnt_d;
  logic               bit_q, bit_d;
  logic               underrun_q, underrun_d;

  logic [C_DAT_W:0]   sum_s;
  logic               xfer_s;
  logic               underrun_set_s;

  // The carry out of the accumulator is the output bit; acc keeps the residue.
  assign sum_s  = {1'b0, acc_q} + {1'b0, active_q};
  assign xfer_s = DAT_VLD_i & ~pend_full_q;

  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    pend_full_d    = pend_full_q;
    active_d       = active_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    bit_d          = bit_q;
    underrun_set_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        acc_d = DAT_ZERO;
        cnt_d = CNT_ZERO;
        bit_d = 1'b0;
        if (RUN_i && EN_CK_i && pend_full_q) begin
          active_d    = pend_q;
          pend_full_d = 1'b0;
          state_d     = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!RUN_i) begin
          state_d = ST_IDLE;
          acc_d   = DAT_ZERO;
          cnt_d   = CNT_ZERO;
          bit_d   = 1'b0;
        end else if (EN_CK_i) begin
          acc_d = sum_s[C_DAT_W-1:0];
          bit_d = sum_s[C_DAT_W];
          // The wrap tick still modulates the old sample; the new one starts next tick.
          if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
            if (pend_full_q) begin
              active_d    = pend_q;
              pend_full_d = 1'b0;
            end else begin
              underrun_set_s = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = DAT_ZERO;
        cnt_d   = CNT_ZERO;
        bit_d   = 1'b0;
      end
    endcase

    // A transfer needs an empty buffer, so it never collides with a load.
    if (xfer_s) begin
      pend_d      = DAT_i;
      pend_full_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end

    if (underrun_set_s) begin
      underrun_d = 1'b1;
    end else if (UNDERRUN_CLR_i) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  always_ff @(posedge CK_i) begin
    if (!XARST_i) begin
      state_q     <= ST_IDLE;
      pend_q      <= DAT_ZERO;
      pend_full_q <= 1'b0;
      active_q    <= DAT_ZERO;
      acc_q       <= DAT_ZERO;
      cnt_q       <= CNT_ZERO;
      bit_q       <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      active_q    <= active_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      underrun_q  <= underrun_d;
    end
  end

  assign DAT_RDY_o  = ~pend_full_q;
  assign BIT_o      = bit_q;
  assign UNDERRUN_o = underrun_q;
  assign ACC_o      = acc_q;

endmodule

// File: tb/tb_delta_sigma_dac.sv
// Scoreboard bench for delta_sigma_dac. The reference model treats the modulator as a running
// integer sum: the output bit is a carry across a multiple of 2^W, and acc is the sum mod 2^W.
module tb_delta_sigma_dac;

  localparam int W   = 8;
  localparam int OSR = 256;

  logic         CK_i = 1'b0;
  logic         XARST_i = 1'b0;
  logic         EN_CK_i = 1'b0;
  logic         RUN_i = 1'b0;
  logic [W-1:0] DAT_i = '0;
  logic         DAT_VLD_i = 1'b0;
  logic         DAT_RDY_o;
  logic         BIT_o;
  logic         UNDERRUN_o;
  logic         UNDERRUN_CLR_i = 1'b0;
  logic [W-1:0] ACC_o;

  delta_sigma_dac #(.C_DAT_W(W), .C_OSR(OSR), .C_OSR_W(8)) dut (
    .CK_i(CK_i), .XARST_i(XARST_i), .EN_CK_i(EN_CK_i), .RUN_i(RUN_i),
    .DAT_i(DAT_i), .DAT_VLD_i(DAT_VLD_i), .DAT_RDY_o(DAT_RDY_o),
    .BIT_o(BIT_o), .UNDERRUN_o(UNDERRUN_o), .UNDERRUN_CLR_i(UNDERRUN_CLR_i),
    .ACC_o(ACC_o)
  );

  always #5 CK_i = ~CK_i;

  typedef struct {
    logic         b;
    logic [W-1:0] acc;
    logic         rdy;
    logic         unr;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] feed[$];
  int           tests = 0;
  int           failed = 0;
  int           cyc = 0;

  // Reference model state.
  bit           m_run, m_pend_full, m_bit, m_unr;
  logic [W-1:0] m_pend, m_active;
  longint       m_total;
  int           m_tick;

  task automatic model_step(input bit rst_n, input bit en, input bit run, input bit vld,
                            input logic [W-1:0] dat, input bit clr, output bit took);
    bit     was_empty;
    bit     set_unr;
    longint old;
    took = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_pend_full = 0; m_bit = 0; m_unr = 0;
      m_pend = '0; m_active = '0; m_total = 0; m_tick = 0;
      return;
    end
    was_empty = !m_pend_full;
    set_unr = 1'b0;
    if (!m_run) begin
      m_total = 0; m_bit = 0; m_tick = 0;
      if (run && en && m_pend_full) begin
        m_active = m_pend; m_pend_full = 0; m_run = 1;
      end
    end else if (!run) begin
      m_run = 0; m_total = 0; m_bit = 0; m_tick = 0;
    end else if (en) begin
      old = m_total;
      m_total = m_total + longint'(m_active);
      m_bit = ((m_total >> W) != (old >> W));
      m_tick++;
      if (m_tick == OSR) begin
        m_tick = 0;
        if (m_pend_full) begin
          m_active = m_pend; m_pend_full = 0;
        end else begin
          set_unr = 1'b1;
        end
      end
    end
    if (vld && was_empty) begin
      m_pend = dat; m_pend_full = 1; took = 1'b1;
    end
    if (set_unr) m_unr = 1;
    else if (clr) m_unr = 0;
  endtask

  task automatic step(input bit rst_n, input bit en, input bit run, input bit clr);
    bit           vld, took;
    logic [W-1:0] dat;
    exp_t         e;
    @(negedge CK_i);
    vld = (feed.size() > 0);
    dat = vld ? feed[0] : W'($urandom);
    XARST_i = rst_n; EN_CK_i = en; RUN_i = run;
    DAT_VLD_i = vld; DAT_i = dat; UNDERRUN_CLR_i = clr;
    model_step(rst_n, en, run, vld, dat, clr, took);
    if (took) void'(feed.pop_front());
    e.b = m_bit; e.acc = W'(m_total % (longint'(1) << W));
    e.rdy = !m_pend_full; e.unr = m_unr; e.cyc = cyc;
    exp_q.push_back(e);
    cyc++;
  endtask

  function automatic bit at_wrap();
    return m_run && (m_tick == OSR - 1);
  endfunction

  task automatic run_to_tick(input int t, input string name);
    int k;
    for (k = 0; k < 3000 && !(m_run && m_tick == t); k++) step(1, 1, 1, 0);
    tests++;
    if (k >= 3000) begin
      failed++;
      $display("FAIL %s: tick %0d not reached, got tick %0d", name, t, m_tick);
    end
  endtask

  // Scoreboard monitor: compares each post-edge output against the queued expectation.
  always @(posedge CK_i) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (BIT_o !== e.b || ACC_o !== e.acc || DAT_RDY_o !== e.rdy || UNDERRUN_o !== e.unr) begin
        failed++;
        $display("FAIL outputs cyc%0d: got bit=%0b acc=%0d rdy=%0b unr=%0b, expected bit=%0b acc=%0d rdy=%0b unr=%0b",
                 e.cyc, BIT_o, ACC_o, DAT_RDY_o, UNDERRUN_O_s(), e.b, e.acc, e.rdy, e.unr);
      end
    end
  end

  function automatic logic UNDERRUN_O_s();
    return UNDERRUN_o;
  endfunction

  initial begin
    // Reset with valid and run asserted: nothing transfers.
    feed = '{8'd128, 8'd64, 8'd255, 8'd32};
    repeat (3) step(0, 1, 1, 0);
    // 128, 64, 255, 32 back to back, then underrun on 32.
    repeat (1040) step(1, 1, 1, 0);
    // Clear pulse, next wrap re-sets; then clear coinciding with wrap.
    step(1, 1, 1, 1);
    repeat (300) step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    repeat (300) step(1, 1, 1, at_wrap());

    // Tick enable active one cycle in four.
    repeat (2) step(0, 1, 1, 0);
    feed = '{8'd128, 8'd200};
    for (int i = 0; i < 1100; i++) step(1, (i % 4) == 0, 1, 0);

    // RUN drop at tick 100 keeps the pending sample.
    feed = '{8'd77};
    run_to_tick(100, "run_drop");
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    repeat (300) step(1, 1, 1, 0);
    // Reset at tick 50 with a sample pending discards it.
    feed = '{8'd99};
    run_to_tick(50, "mid_reset");
    step(0, 1, 1, 0);
    repeat (5) step(1, 1, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (feed.size() == 0 && $urandom_range(0, 3) == 0) feed.push_back(W'($urandom));
      step(($urandom_range(0, 499) != 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0));
    end

    @(posedge CK_i);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
